// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file, two async read ports, one sync write port
// Optional write-to-read bypass and hardwired-zero register 0.
module reg_file_param #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] src_reg1,
   input  logic [ADDR_W-1:0] src_reg2,
   input  logic [ADDR_W-1:0] dst_reg,
   input  logic              write_reg,
   input  logic [WIDTH-1:0]  dst_data,
   output logic [WIDTH-1:0]  src_data1,
   output logic [WIDTH-1:0]  src_data2
);

   logic             wr_eff;
   logic             byp1;
   logic             byp2;
   logic [WIDTH-1:0] sel1 [DEPTH];
   logic [WIDTH-1:0] sel2 [DEPTH];
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;

   assign wr_eff = write_reg && !rst && (32'(dst_reg) < DEPTH)
                   && !((ZERO_REG != 0) && (dst_reg == '0));

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_reg
         if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign sel1[i] = '0;
            assign sel2[i] = '0;
         end else begin : g_store
            logic             we;
            logic [WIDTH-1:0] r;

            assign we = wr_eff && (dst_reg == ADDR_W'(i));

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  r <= '0;
               end else if (we) begin
                  r <= dst_data;
               end
            end

            assign sel1[i] = (src_reg1 == ADDR_W'(i)) ? r : '0;
            assign sel2[i] = (src_reg2 == ADDR_W'(i)) ? r : '0;
         end
      end
   endgenerate

   // Out-of-range addresses match no register, so the OR-reduction yields 0.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         rd1 = rd1 | sel1[k];
         rd2 = rd2 | sel2[k];
      end
   end

   assign byp1 = (BYPASS != 0) && wr_eff && (dst_reg == src_reg1);
   assign byp2 = (BYPASS != 0) && wr_eff && (dst_reg == src_reg2);

   assign src_data1 = rst ? '0 : (byp1 ? dst_data : rd1);
   assign src_data2 = rst ? '0 : (byp2 ? dst_data : rd2);

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param (bypass/zero-reg and no-bypass/depth-12 builds)
module tb_reg_file_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  src_reg1, src_reg2, dst_reg;
   logic        write_reg;
   logic [15:0] dst_data;
   logic [15:0] a1, a2, b1, b2;

   logic [15:0] ma [16];
   logic [15:0] mb [16];
   logic [15:0] exp_q [$];
   string       tag_q [$];
   int          vectors = 0;
   int          miscompares = 0;

   reg_file_param #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2), .dst_reg(dst_reg),
      .write_reg(write_reg), .dst_data(dst_data), .src_data1(a1), .src_data2(a2)
   );

   reg_file_param #(.WIDTH(16), .DEPTH(12), .ADDR_W(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2), .dst_reg(dst_reg),
      .write_reg(write_reg), .dst_data(dst_data), .src_data1(b1), .src_data2(b2)
   );

   always #10 clk = ~clk;

   function automatic logic [15:0] exp_a(input logic [3:0] s);
      if (rst) return 16'h0;
      if (s == 4'd0) return 16'h0;
      if (write_reg && dst_reg == s) return dst_data;
      return ma[s];
   endfunction

   function automatic logic [15:0] exp_b(input logic [3:0] s);
      if (rst) return 16'h0;
      if (s >= 4'd12) return 16'h0;
      return mb[s];
   endfunction

   task automatic clear_models();
      for (int k = 0; k < 16; k++) begin
         ma[k] = 16'h0;
         mb[k] = 16'h0;
      end
   endtask

   task automatic push_exp(input string tag);
      exp_q.push_back(exp_a(src_reg1)); tag_q.push_back({tag, ".a1"});
      exp_q.push_back(exp_a(src_reg2)); tag_q.push_back({tag, ".a2"});
      exp_q.push_back(exp_b(src_reg1)); tag_q.push_back({tag, ".b1"});
      exp_q.push_back(exp_b(src_reg2)); tag_q.push_back({tag, ".b2"});
   endtask

   task automatic check_out();
      logic [15:0] obs [4];
      logic [15:0] e;
      string       t;
      obs = '{a1, a2, b1, b2};
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         vectors++;
         assert (obs[k] === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, obs[k], e);
         end
      end
   endtask

   task automatic sample(input string tag);
      push_exp(tag);
      check_out();
   endtask

   task automatic step(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input logic we, input logic [15:0] data, input string tag);
      @(negedge clk);
      src_reg1 = s1; src_reg2 = s2; dst_reg = d; write_reg = we; dst_data = data;
      #1;
      sample(tag);
      @(posedge clk);
      if (!rst && write_reg) begin
         if (dst_reg != 4'd0) ma[dst_reg] = dst_data;
         if (dst_reg < 4'd12) mb[dst_reg] = dst_data;
      end
   endtask

   initial begin
      rst = 1'b0;
      src_reg1 = 4'd0; src_reg2 = 4'd0; dst_reg = 4'd0; write_reg = 1'b0; dst_data = 16'h0;
      clear_models();
      #1 rst = 1'b1;
      #2 sample("reset");
      @(negedge clk);
      rst = 1'b0;

      // asynchronous reset between edges
      step(4'd3, 4'd3, 4'd3, 1'b1, 16'hBEEF, "wr3");
      step(4'd3, 4'd3, 4'd0, 1'b0, 16'h0, "rd3");
      #2 rst = 1'b1;
      clear_models();
      #2 sample("rst_async");
      #2 rst = 1'b0;
      #2 sample("rst_rel");

      // latency and bypass
      step(4'd5, 4'd5, 4'd5, 1'b1, 16'h1234, "lat_n");
      step(4'd5, 4'd5, 4'd0, 1'b0, 16'h0, "lat_n1");
      step(4'd7, 4'd7, 4'd7, 1'b1, 16'hA5A5, "byp");
      step(4'd7, 4'd7, 4'd0, 1'b0, 16'h0, "byp_after");

      // zero register
      step(4'd0, 4'd0, 4'd0, 1'b1, 16'hFFFF, "zero");
      step(4'd0, 4'd0, 4'd0, 1'b0, 16'h0, "zero_after");

      // out-of-range write and full sweep
      step(4'd13, 4'd11, 4'd13, 1'b1, 16'h5555, "oor");
      step(4'd13, 4'd12, 4'd0, 1'b0, 16'h0, "oor_after");
      for (int k = 0; k < 12; k++)
         step(4'(k), 4'(11 - k), 4'(k), 1'b1, 16'(k * 16'h1111), $sformatf("wr%0d", k));
      for (int k = 0; k < 16; k++)
         step(4'(k), 4'(15 - k), 4'd0, 1'b0, 16'h0, $sformatf("rd%0d", k));

      for (int k = 0; k < 24; k++)
         step(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
              1'($urandom_range(1)), 16'($urandom), $sformatf("rnd%0d", k));

      // reset colliding with a pending write
      @(negedge clk);
      src_reg1 = 4'd2; src_reg2 = 4'd2; dst_reg = 4'd2; write_reg = 1'b1; dst_data = 16'h00FF;
      #1 sample("coll_pre");
      #7 rst = 1'b1;
      clear_models();
      #1 sample("coll_rst");
      @(posedge clk);
      #2 sample("coll_edge");
      write_reg = 1'b0;
      #2 rst = 1'b0;
      #1 sample("coll_rel");
      step(4'd2, 4'd3, 4'd0, 1'b0, 16'h0, "coll_rd");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
